interrupt_ack_sequencer: RTL

Upstream neighbour of the cascade-signal logic. It tracks the CPU's INTA pulse train and produces the control state (READY/ACK1/ACK2/ACK3). It latches the one-hot acknowledged level consumed by the cascade block and drives the vector/CALL bytes onto the internal data bus. It also issues the end-of-acknowledge pulse used by the in-service logic.

---
 rtl/interrupt_ack_sequencer_if.sv | 36 +++
 rtl/interrupt_ack_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/interrupt_ack_sequencer_if.sv
// Acknowledge-sequencer bus: INTA pin, priority/config inputs and the
// state, level and data-bus outputs shared with the cascade and in-service logic.
interface interrupt_ack_sequencer_if;
  logic       interrupt_acknowledge_n;
  logic [7:0] highest_request;
  logic       u8086_or_mcs80_config;
  logic       call_address_interval_4_config;
  logic [2:0] vector_address_low;
  logic [7:0] vector_address_high;
  logic       cascade_slave;
  logic       cascade_output_ack_2_3;
  logic       auto_eoi_config;

  logic [2:0] control_state;
  logic [7:0] acknowledge_interrupt;
  logic       end_of_acknowledge_sequence;
  logic [7:0] auto_eoi_clear;
  logic [7:0] data_out;
  logic       data_out_enable;

  modport slave (
    input  interrupt_acknowledge_n, highest_request, u8086_or_mcs80_config,
           call_address_interval_4_config, vector_address_low, vector_address_high,
           cascade_slave, cascade_output_ack_2_3, auto_eoi_config,
    output control_state, acknowledge_interrupt, end_of_acknowledge_sequence,
           auto_eoi_clear, data_out, data_out_enable
  );

  modport master (
    output interrupt_acknowledge_n, highest_request, u8086_or_mcs80_config,
           call_address_interval_4_config, vector_address_low, vector_address_high,
           cascade_slave, cascade_output_ack_2_3, auto_eoi_config,
    input  control_state, acknowledge_interrupt, end_of_acknowledge_sequence,
           auto_eoi_clear, data_out, data_out_enable
  );
endinterface

// File: rtl/interrupt_ack_sequencer.sv
// INTA pulse-train sequencer: tracks READY/ACK1/ACK2/ACK3, latches the acknowledged
// level, drives vector/CALL bytes and pulses end-of-acknowledge. Optional macro: AUTO_EOI_EN.
module interrupt_ack_sequencer #(
  parameter logic [2:0] READY_STATE    = 3'b000,
  parameter logic [2:0] ACK1_STATE     = 3'b001,
  parameter logic [2:0] ACK2_STATE     = 3'b010,
  parameter logic [2:0] ACK3_STATE     = 3'b011,
  parameter int         SPURIOUS_LEVEL = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  interrupt_ack_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_READY = READY_STATE,
    S_ACK1  = ACK1_STATE,
    S_ACK2  = ACK2_STATE,
    S_ACK3  = ACK3_STATE
  } state_t;

  localparam logic [7:0] SPURIOUS_ONEHOT = 8'(1 << ((1 << SPURIOUS_LEVEL) - 1));

  state_t     r_state;
  logic       r_inta_q;
  logic       r_mode_8086;
  logic       r_eoa;
  logic [7:0] r_ack;
  logic [7:0] r_data;
  logic       r_data_en;
`ifdef AUTO_EOI_EN
  logic [7:0] r_aeoi;
`endif

  logic       w_fall;
  logic       w_rise;
  logic       w_done;
  logic [2:0] w_level;
  logic [8:0] w_byte;
  logic       w_drive;

  function automatic logic [2:0] f_level(input logic [7:0] onehot);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (onehot[i]) idx = i[2:0];
    return idx;
  endfunction

  // {defined, byte} for the byte the CPU expects in a given acknowledge state
  function automatic logic [8:0] f_byte(input state_t st, input logic mode_8086,
                                        input logic [2:0] lvl, input logic [2:0] vl,
                                        input logic [7:0] vh, input logic int4,
                                        input logic slave);
    logic       def;
    logic [7:0] b;
    def = 1'b0;
    b   = 8'h00;
    if (mode_8086) begin
      if (st == S_ACK2) begin
        def = 1'b1;
        b   = {vh[7:3], lvl};
      end
    end else begin
      case (st)
        S_ACK1: begin
          def = ~slave;
          b   = 8'hCD;
        end
        S_ACK2: begin
          def = 1'b1;
          b   = int4 ? {vl, lvl, 2'b00} : {vl[2:1], lvl, 3'b000};
        end
        S_ACK3: begin
          def = 1'b1;
          b   = vh;
        end
        default: ;
      endcase
    end
    return {def, b};
  endfunction

  assign w_fall  = r_inta_q & ~bus.interrupt_acknowledge_n;
  assign w_rise  = ~r_inta_q & bus.interrupt_acknowledge_n;
  assign w_done  = w_rise & (((r_state == S_ACK2) & r_mode_8086) | (r_state == S_ACK3));
  assign w_level = f_level(r_ack);
  assign w_byte  = f_byte(r_state, r_mode_8086, w_level, bus.vector_address_low,
                          bus.vector_address_high, bus.call_address_interval_4_config,
                          bus.cascade_slave);
  assign w_drive = ~bus.interrupt_acknowledge_n & (r_state != S_READY) & w_byte[8] &
                   ((r_state == S_ACK1) | bus.cascade_output_ack_2_3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_READY;
      r_inta_q    <= 1'b1;
      r_mode_8086 <= 1'b1;
      r_eoa       <= 1'b0;
      r_ack       <= 8'h00;
      r_data      <= 8'h00;
      r_data_en   <= 1'b0;
`ifdef AUTO_EOI_EN
      r_aeoi      <= 8'h00;
`endif
    end else begin
      r_inta_q  <= bus.interrupt_acknowledge_n;
      r_eoa     <= 1'b0;
      r_data    <= w_byte[7:0];
      r_data_en <= w_drive;
`ifdef AUTO_EOI_EN
      r_aeoi    <= 8'h00;
`endif
      if (w_done) begin
        r_state <= S_READY;
        r_eoa   <= 1'b1;
        r_ack   <= 8'h00;
`ifdef AUTO_EOI_EN
        r_aeoi  <= bus.auto_eoi_config ? r_ack : 8'h00;
`endif
      end else begin
        case (r_state)
          // a fall landing in the end-pulse cycle is deliberately dropped
          S_READY: if (w_fall && !r_eoa) begin
            r_state     <= S_ACK1;
            r_ack       <= (bus.highest_request == 8'h00) ? SPURIOUS_ONEHOT : bus.highest_request;
            r_mode_8086 <= bus.u8086_or_mcs80_config;
          end
          S_ACK1: if (w_fall) r_state <= S_ACK2;
          S_ACK2: if (!r_mode_8086 && w_fall) r_state <= S_ACK3;
          S_ACK3: ;
          default: r_state <= S_READY;
        endcase
      end
    end
  end

  assign bus.control_state               = r_state;
  assign bus.acknowledge_interrupt       = r_ack;
  assign bus.end_of_acknowledge_sequence = r_eoa;
  assign bus.data_out                    = r_data;
  assign bus.data_out_enable             = r_data_en;
`ifdef AUTO_EOI_EN
  assign bus.auto_eoi_clear              = r_aeoi;
`else
  assign bus.auto_eoi_clear              = 8'h00;
`endif

endmodule
